// File: rtl/des_key_schedule.sv
// ============================================================================
// Module   : des_key_schedule
// Purpose  : Produces the sixteen 48-bit DES round subkeys from a 64-bit key,
//            one per valid/ready transfer, by rotating registered C/D halves
//            and applying PC-2 combinationally.
// Options  : DES_KS_DECRYPT_EN - when defined, honours 'decrypt' (K16..K1
//            order via right rotation); otherwise encrypt order only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_key_schedule (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] key,
   input  logic        decrypt,
   input  logic        start,
   output logic        key_ready,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  subkey_round,
   output logic        done
);

   // PC-1: FIPS key bit numbers selected into C (first 28) then D (last 28).
   localparam int c_pc1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   // PC-2: positions 1..56 of the concatenated C|D selected into the subkey.
   localparam int c_pc2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_round;
   logic        r_done;
   logic        w_accept;
   logic        w_xfer;
   logic        w_last;
   logic        w_two;
   logic [3:0]  w_round_next;
   logic [55:0] w_pc1;
   logic [27:0] w_c_start;
   logic [27:0] w_d_start;
   logic [27:0] w_c_next;
   logic [27:0] w_d_next;
   logic        w_unused_parity;
`ifdef DES_KS_DECRYPT_EN
   logic        r_decrypt;
`else
   logic        w_unused_decrypt;
   assign w_unused_decrypt = decrypt;
`endif

   // FIPS bit n of the key is key[64-n]; bit 1 of the result lands in the MSB.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] o;
      o = '0;
      for (int i = 0; i < 56; i++)
         o[6'(55 - i)] = k[6'(64 - c_pc1[i])];
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] o;
      o = '0;
      for (int i = 0; i < 48; i++)
         o[6'(47 - i)] = cd[6'(56 - c_pc2[i])];
      return o;
   endfunction

   // Left rotation moves FIPS bit 2 into bit 1 (MSB side of the ring).
   function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
      return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
   endfunction

`ifdef DES_KS_DECRYPT_EN
   function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
      return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
   endfunction
`endif

   // Parity bits of the key never influence the schedule.
   assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                              key[24], key[16], key[8], key[0]};

   assign w_pc1        = pc1(key);
   assign w_last       = (r_round == 4'd15);
   assign w_round_next = r_round + 4'd1;
   // Rounds 1, 8 and 15 step by one position, every other round by two.
   assign w_two        = !((w_round_next == 4'd1) || (w_round_next == 4'd8) ||
                           (w_round_next == 4'd15));
   assign subkey       = pc2({r_c, r_d});
   assign subkey_round = r_round;
   assign done         = r_done;

   // Initial C/D: encrypt pre-rotates by one for round 0; decrypt uses PC-1 as is.
   always_comb begin
      w_c_start = rotl(w_pc1[55:28], 1'b0);
      w_d_start = rotl(w_pc1[27:0], 1'b0);
`ifdef DES_KS_DECRYPT_EN
      if (decrypt) begin
         w_c_start = w_pc1[55:28];
         w_d_start = w_pc1[27:0];
      end
`endif
   end

   // Per-round advance of C and D, each as an independent 28-bit ring.
   always_comb begin
      w_c_next = rotl(r_c, w_two);
      w_d_next = rotl(r_d, w_two);
`ifdef DES_KS_DECRYPT_EN
      if (r_decrypt) begin
         w_c_next = rotr(r_c, w_two);
         w_d_next = rotr(r_d, w_two);
      end
`endif
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      key_ready    = 1'b0;
      subkey_valid = 1'b0;
      w_accept     = 1'b0;
      w_xfer       = 1'b0;
      case (r_state)
         S_IDLE: begin
            key_ready = 1'b1;
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            subkey_valid = 1'b1;
            if (subkey_ready) begin
               w_xfer = 1'b1;
               if (w_last) w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // C/D halves, round counter, mode capture and the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c     <= '0;
         r_d     <= '0;
         r_round <= '0;
         r_done  <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
         r_decrypt <= 1'b0;
`endif
      end else begin
         r_done <= w_xfer && w_last;
         if (w_accept) begin
            r_c     <= w_c_start;
            r_d     <= w_d_start;
            r_round <= '0;
`ifdef DES_KS_DECRYPT_EN
            r_decrypt <= decrypt;
`endif
         end else if (w_xfer && !w_last) begin
            r_c     <= w_c_next;
            r_d     <= w_d_next;
            r_round <= w_round_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
// ============================================================================
// Module   : tb_des_key_schedule
// Purpose  : Self-checking bench for des_key_schedule: known-answer vectors,
//            random keys with backpressure against a table-level DES model,
//            ignored start during ISSUE, reset mid-schedule, parity bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_key_schedule;

   logic        clk;
   logic        rst;
   logic [63:0] key;
   logic        decrypt;
   logic        start;
   logic        key_ready;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [3:0]  subkey_round;
   logic        done;

   int n_checks;
   int n_fail;

   localparam logic [63:0] c_key    = 64'h133457799BBCDFF1;
   localparam logic [63:0] c_parity = 64'h0101010101010101;

   des_key_schedule dut (
      .clk          (clk),
      .rst          (rst),
      .key          (key),
      .decrypt      (decrypt),
      .start        (start),
      .key_ready    (key_ready),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey_round (subkey_round),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DES tables in FIPS 1-based numbering for the reference model.
   int pc1_t [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   int pc2_t [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int shift_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic [47:0] exp_ks [16];
   logic [47:0] got_ks [16];

   // Reference: cumulative left offset into the C and D rings, then PC-2.
   // Decrypt order is simply the encrypt list reversed.
   task automatic build_model(input logic [63:0] k, input bit dec);
      bit          cd [1:56];
      logic [47:0] enc [16];
      int          tot;
      int          pos;
      bit          use_dec;
      for (int i = 0; i < 56; i++) cd[i + 1] = k[64 - pc1_t[i]];
      tot = 0;
      for (int r = 0; r < 16; r++) begin
         tot += shift_t[r];
         enc[r] = '0;
         for (int i = 0; i < 48; i++) begin
            pos = pc2_t[i];
            if (pos <= 28) enc[r][47 - i] = cd[1 + ((pos - 1 + tot) % 28)];
            else           enc[r][47 - i] = cd[29 + ((pos - 29 + tot) % 28)];
         end
      end
`ifdef DES_KS_DECRYPT_EN
      use_dec = dec;
`else
      use_dec = 1'b0;
`endif
      for (int r = 0; r < 16; r++) exp_ks[r] = use_dec ? enc[15 - r] : enc[r];
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Runs one full schedule from IDLE. Called at a post-edge sampling point.
   task automatic run_schedule(input logic [63:0] k, input bit dec, input bit bp,
                               input bit inj, output int cycles);
      int          cnt;
      int          budget;
      bit          pstall;
      logic [47:0] psk;
      logic [3:0]  prnd;
      cnt = 0; cycles = 0; budget = 0; pstall = 1'b0; psk = '0; prnd = '0;
      chk("idle_key_ready", key_ready, 1);
      key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      key = {$urandom, $urandom};
      decrypt = ~dec;
      chk("latency1_valid", subkey_valid, 1);
      while (cnt < 16 && budget < 400) begin
         budget++;
         if (pstall) begin
            chk("stall_subkey_stable", subkey, psk);
            chk("stall_round_stable", subkey_round, prnd);
         end
         chk("issue_valid", subkey_valid, 1);
         chk("issue_done_low", done, 0);
         chk("issue_key_ready_low", key_ready, 0);
         if (inj && cnt == 5) begin
            start = 1'b1;
            key = ~k;
            decrypt = ~dec;
         end else begin
            start = 1'b0;
         end
         subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (subkey_valid && subkey_ready) begin
            got_ks[cnt] = subkey;
            chk("round_index", subkey_round, cnt);
            cnt++;
            pstall = 1'b0;
         end else begin
            pstall = subkey_valid;
            psk = subkey;
            prnd = subkey_round;
         end
         cycles++;
         @(posedge clk); #1;
      end
      start = 1'b0; subkey_ready = 1'b0;
      chk("transfer_count", cnt, 16);
      chk("end_done_pulse", done, 1);
      chk("end_valid_low", subkey_valid, 0);
      chk("end_key_ready", key_ready, 1);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
   endtask

   typedef struct {
      logic [63:0] key;
      bit          dec;
      int          rnd;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs [8];
   int   cyc;
   int   waitc;
   logic [63:0] rk;
   bit   rdec;

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; key = '0; decrypt = 1'b0; start = 1'b0; subkey_ready = 1'b0;

      vecs[0] = '{c_key,            1'b0, 0,  48'h1B02EFFC7072};
      vecs[1] = '{c_key,            1'b0, 1,  48'h79AED9DBC9E5};
      vecs[2] = '{c_key,            1'b0, 15, 48'hCB3D8B0E17F5};
      vecs[3] = '{c_key ^ c_parity, 1'b0, 0,  48'h1B02EFFC7072};
      vecs[4] = '{c_key ^ c_parity, 1'b0, 15, 48'hCB3D8B0E17F5};
`ifdef DES_KS_DECRYPT_EN
      vecs[5] = '{c_key,            1'b1, 0,  48'hCB3D8B0E17F5};
      vecs[6] = '{c_key,            1'b1, 14, 48'h79AED9DBC9E5};
      vecs[7] = '{c_key,            1'b1, 15, 48'h1B02EFFC7072};
`else
      vecs[5] = '{c_key,            1'b1, 0,  48'h1B02EFFC7072};
      vecs[6] = '{c_key,            1'b1, 1,  48'h79AED9DBC9E5};
      vecs[7] = '{c_key,            1'b1, 15, 48'hCB3D8B0E17F5};
`endif

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_key_ready", key_ready, 1);
      chk("reset_valid", subkey_valid, 0);
      chk("reset_subkey", subkey, 0);
      chk("reset_round", subkey_round, 0);
      chk("reset_done", done, 0);

      // Known-answer vectors, ready held high.
      for (int v = 0; v < 8; v++) begin
         run_schedule(vecs[v].key, vecs[v].dec, 1'b0, 1'b0, cyc);
         chk("kat_subkey", got_ks[vecs[v].rnd], vecs[v].exp);
         chk("kat_consecutive_cycles", cyc, 16);
      end

      // Random keys and modes with random backpressure; first run also
      // pulses start with a different key mid-schedule.
      for (int t = 0; t < 6; t++) begin
         rk = {$urandom, $urandom};
         rdec = 1'($urandom_range(0, 1));
         build_model(rk, rdec);
         run_schedule(rk, rdec, 1'b1, (t == 0), cyc);
         for (int r = 0; r < 16; r++) chk("rand_subkey", got_ks[r], exp_ks[r]);
      end

      // Parity-flipped key yields the same full schedule.
      build_model(c_key, 1'b1);
      run_schedule(c_key ^ c_parity, 1'b1, 1'b1, 1'b0, cyc);
      for (int r = 0; r < 16; r++) chk("parity_subkey", got_ks[r], exp_ks[r]);

      // Reset asserted while round 7 is presented, with a competing start.
      key = c_key; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; subkey_ready = 1'b1;
      waitc = 0;
      while (subkey_round != 4'd7 && waitc < 20) begin
         waitc++;
         @(posedge clk); #1;
      end
      chk("reached_round7", subkey_round, 7);
      rst = 1'b1; start = 1'b1; key = ~c_key;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; subkey_ready = 1'b0;
      chk("rst_valid", subkey_valid, 0);
      chk("rst_key_ready", key_ready, 1);
      chk("rst_subkey", subkey, 0);
      chk("rst_round", subkey_round, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1;
      chk("rst_start_ignored", subkey_valid, 0);
      run_schedule(c_key, 1'b0, 1'b0, 1'b0, cyc);
      chk("post_rst_round0", got_ks[0], 48'h1B02EFFC7072);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
